// File: rtl/uart_tx_frame_if.sv
// Byte-wide valid/ready handshake feeding the UART transmitter.
interface uart_tx_frame_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (output TX_DATA, output TX_VALID, input TX_READY);
  modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: latches one byte per handshake and shifts out
// start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           FPGA_CLK,
  input  logic           RST_N,
  uart_tx_frame_if.slave tx,
  output logic           UART_TXD,
  output logic           TX_BUSY,
  output logic           TX_DONE
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam bit                PAR_EN    = (PARITY == 1) || (PARITY == 2);
  localparam bit                PAR_ODD   = (PARITY == 1);
  localparam logic [2:0]        STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              parity_bit;
  logic              rst_seen;
  logic              bit_end;

  assign bit_end     = (baud_cnt == BAUD_LAST);
  assign tx.TX_READY = (state == S_IDLE) && rst_seen;
  assign TX_BUSY     = (state != S_IDLE);

  always_ff @(posedge FPGA_CLK) begin
    if (!RST_N) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      UART_TXD <= 1'b1;
      TX_DONE  <= 1'b0;
      rst_seen <= 1'b0;
      // NOTE: shift_reg and parity_bit are pure datapath, always reloaded on
      // accept, so they are deliberately left out of reset.
    end else begin
      rst_seen <= 1'b1;
      TX_DONE  <= 1'b0;
      if (state != S_IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (tx.TX_VALID && tx.TX_READY) begin
            shift_reg  <= tx.TX_DATA;
            parity_bit <= (^tx.TX_DATA) ^ PAR_ODD;
            UART_TXD   <= 1'b0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            UART_TXD <= shift_reg[0];
            bit_idx  <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PAR_EN) begin
                UART_TXD <= parity_bit;
                state    <= S_PARITY;
              end else begin
                UART_TXD <= 1'b1;
                state    <= S_STOP;
              end
            end else begin
              UART_TXD <= shift_reg[1];
              bit_idx  <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            UART_TXD <= 1'b1;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          // Raised one edge early so the registered pulse sits on the final stop cycle.
          if (bit_idx == STOP_LAST && baud_cnt == BAUD_PRE) TX_DONE <= 1'b1;
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench: three transmitter variants, a cycle-exact line model
// built from the frame rules, and a monitor that pops expected bytes.
module tb_uart_tx_frame;
  localparam int CPB = 4;

  function automatic int par_of(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction
  function automatic int stops_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction
  function automatic int pen_of(input int i);
    return (par_of(i) == 1 || par_of(i) == 2) ? 1 : 0;
  endfunction
  function automatic int frame_len(input int i);
    return (9 + pen_of(i) + stops_of(i)) * CPB;
  endfunction
  function automatic logic exp_bit(input logic [7:0] d, input int i, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (pen_of(i) == 1 && slot == 9) return (^d) ^ (par_of(i) == 1);
    return 1'b1;
  endfunction

  typedef struct {
    logic [7:0] data;
    int         acc_cyc;
    bit         abort;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_prev = 1'b0;
  int         cyc = 0;
  int         sel = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_busy = 1'b0;
  exp_t       exp_q[$];

  logic [7:0] tx_data [3];
  logic       tx_valid[3];
  logic       ready_w [3];
  logic       txd_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst_n;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_frame_if bus();
    assign bus.TX_DATA  = tx_data[g];
    assign bus.TX_VALID = tx_valid[g];
    assign ready_w[g]   = bus.TX_READY;

    uart_tx_frame #(
      .CLKS_PER_BIT(CPB),
      .PARITY      (par_of(g)),
      .STOP_BITS   (stops_of(g))
    ) u_dut (
      .FPGA_CLK(clk),
      .RST_N   (rst_n),
      .tx      (bus),
      .UART_TXD(txd_w[g]),
      .TX_BUSY (busy_w[g]),
      .TX_DONE (done_w[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, cycle %0d)", name, got, exp, sel, cyc);
    end
  endtask

  // Present a byte, wait for the handshake, and record what the line must carry.
  task automatic send(input logic [7:0] d, input bit hold, input bit abort_exp, output int acc);
    int t;
    t = 0;
    acc = -1;
    tx_data[sel]  = d;
    tx_valid[sel] = 1'b1;
    while (ready_w[sel] !== 1'b1) begin
      @(posedge clk); #1;
      t++;
      if (t > 4000) begin
        check("send_timeout", 32'(t), 32'(0));
        tx_valid[sel] = 1'b0;
        return;
      end
    end
    acc = cyc + 1;
    exp_q.push_back('{data: d, acc_cyc: acc, abort: abort_exp});
    @(posedge clk); #1;
    if (!hold) tx_valid[sel] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((mon_busy || exp_q.size() != 0 || busy_w[sel] !== 1'b0) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", 32'(t >= 5000), 32'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: idle line checks every cycle, cycle-exact frame checks on a start bit.
  initial begin : monitor
    exp_t       e;
    int         flen, line_err, ctl_err, done_cnt, done_pos;
    logic [7:0] rx;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_prev !== 1'b1 || txd_w[sel] !== 1'b0) begin
        check("idle_line", 32'({txd_w[sel], busy_w[sel], done_w[sel]}), 32'(3'b100));
      end else begin
        mon_busy = 1'b1;
        check("frame_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() == 0) begin
          for (int t = 0; t < 5000 && busy_w[sel] !== 1'b0; t++) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          check("start_latency", 32'(cyc), 32'(e.acc_cyc));
          flen = frame_len(sel);
          line_err = 0; ctl_err = 0; done_cnt = 0; done_pos = -1; rx = '0; aborted = 1'b0;
          for (int c = 0; c < flen; c++) begin
            if (c > 0) @(negedge clk);
            if (rst_prev !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (txd_w[sel] !== exp_bit(e.data, sel, c / CPB)) line_err++;
            if (busy_w[sel] !== 1'b1 || ready_w[sel] !== 1'b0) ctl_err++;
            if (done_w[sel] === 1'b1) begin
              done_cnt++;
              done_pos = c;
            end
            if (c % CPB == CPB / 2 && c / CPB >= 1 && c / CPB <= 8) rx[c / CPB - 1] = txd_w[sel];
          end
          check("abort_expected", 32'(aborted), 32'(e.abort));
          if (aborted) begin
            check("abort_line", 32'({txd_w[sel], busy_w[sel], done_w[sel]}), 32'(3'b100));
            check("abort_no_done", 32'(done_cnt), 32'(0));
          end else begin
            check("rx_byte", 32'(rx), 32'(e.data));
            check("line_bits", 32'(line_err), 32'(0));
            check("busy_ready_in_frame", 32'(ctl_err), 32'(0));
            check("done_count", 32'(done_cnt), 32'(1));
            check("done_position", 32'(done_pos), 32'(flen - 1));
            @(negedge clk);
            check("post_frame", 32'({txd_w[sel], busy_w[sel], done_w[sel], ready_w[sel]}),
                  32'(4'b1001));
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int         a1, a2, gap;
    logic [7:0] b;
    bit         hold;

    for (int i = 0; i < 3; i++) begin
      tx_data[i]  = 8'h00;
      tx_valid[i] = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      check("ready_in_reset", 32'(ready_w[i]), 32'(0));
    end
    sel = 0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_reset", 32'(ready_w[0]), 32'(1));

    // Basic frame with defaults.
    send(8'h55, 1'b0, 1'b0, a1);
    wait_idle();

    // Back-to-back with valid held high.
    send(8'hA5, 1'b1, 1'b0, a1);
    send(8'h3C, 1'b0, 1'b0, a2);
    check("b2b_spacing", 32'(a2 - a1), 32'(frame_len(0) + 1));
    wait_idle();

    // New data and valid offered mid-frame must be ignored.
    send(8'h00, 1'b0, 1'b0, a1);
    repeat (14) @(posedge clk);
    #1;
    tx_data[0]  = 8'hFF;
    tx_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_valid[0] = 1'b0;
    wait_idle();
    repeat (60) @(posedge clk);
    #1;

    // Reset during data bit 3 aborts the frame; the next frame is clean.
    send(8'hC3, 1'b0, 1'b1, a1);
    repeat (17) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("ready_after_abort", 32'(ready_w[0]), 32'(1));
    send(8'h81, 1'b0, 1'b0, a1);
    wait_idle();

    // Parity variants, then randomized traffic on every variant.
    for (int i = 0; i < 3; i++) begin
      sel = i;
      if (i > 0) begin
        send(8'h07, 1'b0, 1'b0, a1);
        wait_idle();
      end
      for (int k = 0; k < 6; k++) begin
        b    = 8'($urandom_range(0, 255));
        hold = ($urandom_range(0, 2) == 0);
        send(b, hold, 1'b0, a1);
        if (hold) begin
          b = 8'($urandom_range(0, 255));
          send(b, 1'b0, 1'b0, a2);
          check("b2b_spacing_rand", 32'(a2 - a1), 32'(frame_len(i) + 1));
        end
        gap = $urandom_range(0, 5);
        repeat (gap) @(posedge clk);
        #1;
      end
      wait_idle();
    end

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
